seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Downstream display stage of the Hanoi game logic.
- Consumes the per-digit BCD outputs of the game: current time/moves, best time/moves, WON and record-break flags.
- Drives an 8-digit multiplexed common-anode 7-segment display.
- Digits 0-3 show time MM.SS; digits 4-7 show moves. The block handles scan timing, anti-ghost dead time, frame snapshotting, leading-zero blanking and record blinking.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SCAN_HZ, 8000, digit-switch rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit slot, minimum 4.
- DEAD_CYCLES, 64, cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- BLINK_HZ, 2, record blink rate; blink phase toggles every BLINK_DIV = CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clock  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- TIME_NUM0..TIME_NUM3  in  8 each  current time digits (NUM0 = minutes tens ... NUM3 = seconds units).
- MOVES_NUM0..MOVES_NUM3  in  8 each  current move digits (NUM0 = thousands).
- BEST_TIME_NUM0..3  in  8 each  best time digits.
- BEST_MOVE_NUM0..3  in  8 each  best move digits.
- SHOW_BEST  in  1  1 = display best values, 0 = current values.
- WON  in  1  game finished.
- REC_BREAK_TIME  in  1  time record broken.
- REC_BREAK_MOVE  in  1  move record broken.
- SEG  out  8  active-low; [6:0] = gfedcba, [7] = dp.
- DIG  out  8  active-low digit enables; DIG[i] = display digit i.

Behaviour:
- Reset (synchronous) sets:
  - SEG = 8'hFF, DIG = 8'hFF.
  - Prescaler = 0, slot index = 0.
  - Blink counter = 0, blink phase = on.
  - Snapshot registers = 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps.
- When the prescaler reaches SCAN_DIV-1, the slot index increments mod 8 on the next edge (7 -> 0).
- Snapshot:
  - When the index wraps 7 -> 0, all 8 selected digits are latched: source = SHOW_BEST ? BEST : current, sampled on that edge.
  - A whole frame therefore shows one consistent value; SHOW_BEST changes take effect at the next frame.
- Slot timing, with p = prescaler:
  - p < DEAD_CYCLES: DIG = 8'hFF. SEG is already registered for the current index.
  - p >= DEAD_CYCLES: DIG = ~(1 << index), unless the digit is blanked; then DIG = 8'hFF.
  - SEG/DIG are registered; one cycle latency from prescaler/index to pins.
- Decode:
  - Values 0-9 use the standard active-low pattern (0 -> 7'b1000000, 8 -> 7'b0000000).
  - Any value > 9 shows '-' (7'b0111111).
- Decimal points:
  - dp is lit on digit 1 always (MM.SS separator).
  - dp is lit on digit 7 when the latched frame was SHOW_BEST.
  - All other dp are off.
- Leading-zero blanking, moves group only:
  - Digit k (4..6) is blanked if it and every digit 4..k-1 are 0.
  - Digit 7 is never blanked.
  - Time digits are never zero-blanked.
- Blink:
  - Blink counter free-runs 0..BLINK_DIV-1 and toggles the phase on wrap.
  - During the off phase, group 0-3 is blanked iff WON && REC_BREAK_TIME; group 4-7 is blanked iff WON && REC_BREAK_MOVE.
  - Blink qualifiers are sampled live, not snapshotted.
- Simultaneous events:
  - The index wrap and snapshot occur on the same edge; the new snapshot applies to slot 0 SEG on that edge.
  - RESET overrides everything.
  - RESET asserted mid-frame blanks the display from the next edge and restarts at slot 0 with a zero snapshot; the first frame then shows 00.00 and moves "0".
- Prescaler and blink counter widths are $clog2 of their divisors; there is no overflow beyond the divisor.

Decomposition:
- Shared package hanoi_disp_pkg holds:
  - The 7-bit segment encodings for 0-9 and dash.
  - SEG_BLANK = 8'hFF.
  - NUM_DIGITS = 8.
  - A digit-group index enum (GRP_TIME, GRP_MOVES).
- One natural sub-module: bcd_to_seg, purely combinational (4-bit value in, 7-bit active-low out, >9 -> dash).
- Scan, snapshot, blanking and blink logic stay in seven_seg_scanner.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 giving SCAN_DIV=10, DEAD_CYCLES=2, BLINK_HZ=5 giving BLINK_DIV=100):
- Reset release:
  - Stimulus: hold RESET 3 cycles, then release.
  - Response: SEG=FF and DIG=FF during reset; first enable DIG=8'hFE at cycle 3 after release (p=2 registered).
  - Each slot enables for 8 cycles with 2 dead; slot order 0..7 repeats every 80 cycles.
- Time frame:
  - Stimulus: TIME=1,2,3,4 after the next wrap.
  - Response: digit0 SEG=8'hF9, digit1 SEG=8'h24 (dp lit), digit2 SEG=8'hB0, digit3 SEG=8'h99.
- Zero blanking:
  - Stimulus: MOVES=0,0,4,2.
  - Response: DIG[4], DIG[5] stay high all frame; digit6 shows 4, digit7 shows 2.
  - Stimulus: MOVES=0,0,0,0.
  - Response: only digit7 is enabled, SEG=8'hC0.
- Snapshot/SHOW_BEST:
  - Stimulus: toggle SHOW_BEST mid-frame at slot 3.
  - Response: slots 3-7 still show current values; the next frame shows BEST with the dp on digit7 lit.
- Record blink:
  - Stimulus: WON=1, REC_BREAK_MOVE=1, REC_BREAK_TIME=0.
  - Response: digits 4-7 are dark for 100 cycles and enabled for the next 100 cycles, alternating; digits 0-3 are never blanked.
- Out-of-range digit:
  - Stimulus: TIME_NUM2=8'd12.
  - Response: digit2 SEG=8'hBF (dash, dp off).

Source files
------------

// File: rtl/hanoi_disp_pkg.sv
// Shared display constants for the Hanoi game's 7-segment stage:
// active-low segment encodings, digit count and digit-group typing.
package hanoi_disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DIG_OFF   = 8'hFF;

  // Active-low gfedcba patterns.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic {
    GRP_TIME  = 1'b0,
    GRP_MOVES = 1'b1
  } digit_grp_e;

  // Digits 0-3 carry MM.SS, digits 4-7 carry the move count.
  function automatic digit_grp_e grp_of(input logic [2:0] idx);
    return idx[2] ? GRP_MOVES : GRP_TIME;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; values above 9
// render as a dash so corrupted digits are visible rather than misleading.
module bcd_to_seg
  import hanoi_disp_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 8-digit multiplexed common-anode display driver for the Hanoi game:
// scan timing with dead time, per-frame snapshot, zero blanking, record blink.
module seven_seg_scanner
  import hanoi_disp_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 8000,
  parameter int DEAD_CYCLES = 64,
  parameter int BLINK_HZ    = 2
) (
  input  logic       clock,
  input  logic       RESET,
  input  logic [7:0] TIME_NUM0,
  input  logic [7:0] TIME_NUM1,
  input  logic [7:0] TIME_NUM2,
  input  logic [7:0] TIME_NUM3,
  input  logic [7:0] MOVES_NUM0,
  input  logic [7:0] MOVES_NUM1,
  input  logic [7:0] MOVES_NUM2,
  input  logic [7:0] MOVES_NUM3,
  input  logic [7:0] BEST_TIME_NUM0,
  input  logic [7:0] BEST_TIME_NUM1,
  input  logic [7:0] BEST_TIME_NUM2,
  input  logic [7:0] BEST_TIME_NUM3,
  input  logic [7:0] BEST_MOVE_NUM0,
  input  logic [7:0] BEST_MOVE_NUM1,
  input  logic [7:0] BEST_MOVE_NUM2,
  input  logic [7:0] BEST_MOVE_NUM3,
  input  logic       SHOW_BEST,
  input  logic       WON,
  input  logic       REC_BREAK_TIME,
  input  logic       REC_BREAK_MOVE,
  output logic [7:0] SEG,
  output logic [7:0] DIG
);

  localparam int SCAN_DIV  = (CLK_HZ / SCAN_HZ < 4) ? 4 : CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = (CLK_HZ / (2 * BLINK_HZ) < 2) ? 2 : CLK_HZ / (2 * BLINK_HZ);
  localparam int PW        = $clog2(SCAN_DIV);
  localparam int BW        = $clog2(BLINK_DIV);

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0]              prescaler;
  logic [2:0]                 slot_idx;
  logic [BW-1:0]              blink_cnt;
  logic                       blink_on;
  logic [NUM_DIGITS-1:0][7:0] snap_digits;
  logic                       snap_best;
  logic [7:0]                 seg_q;
  logic [7:0]                 dig_q;

  logic                       scan_wrap;
  logic                       frame_wrap;
  logic                       blink_wrap;
  logic [NUM_DIGITS-1:0][7:0] src_digits;
  logic [7:0]                 cur_digit;
  logic [3:0]                 dec_val;
  logic [6:0]                 seg_pat;
  logic                       dp_lit;
  logic                       lz4;
  logic                       lz5;
  logic                       lz6;
  logic                       zero_blank;
  logic                       blink_blank;
  logic [7:0]                 seg_d;
  logic [7:0]                 dig_d;

  assign scan_wrap  = (prescaler == P_LAST);
  assign frame_wrap = scan_wrap && (slot_idx == 3'd7);
  assign blink_wrap = (blink_cnt == B_LAST);

  // Digit 7 sits in the MSB lane so snap_digits[i] is display digit i.
  always_comb begin
    src_digits = '0;
    if (SHOW_BEST) begin
      src_digits = {BEST_MOVE_NUM3, BEST_MOVE_NUM2, BEST_MOVE_NUM1, BEST_MOVE_NUM0,
                    BEST_TIME_NUM3, BEST_TIME_NUM2, BEST_TIME_NUM1, BEST_TIME_NUM0};
    end else begin
      src_digits = {MOVES_NUM3, MOVES_NUM2, MOVES_NUM1, MOVES_NUM0,
                    TIME_NUM3, TIME_NUM2, TIME_NUM1, TIME_NUM0};
    end
  end

  // The full 8-bit value is range-checked so e.g. 18 cannot alias to 2.
  assign cur_digit = snap_digits[slot_idx];
  assign dec_val   = (cur_digit > 8'd9) ? 4'hF : cur_digit[3:0];

  bcd_to_seg u_bcd_to_seg (
    .value (dec_val),
    .seg   (seg_pat)
  );

  assign dp_lit = (slot_idx == 3'd1) || ((slot_idx == 3'd7) && snap_best);

  assign lz4 = (snap_digits[4] == 8'd0);
  assign lz5 = lz4 && (snap_digits[5] == 8'd0);
  assign lz6 = lz5 && (snap_digits[6] == 8'd0);

  always_comb begin
    zero_blank = 1'b0;
    case (slot_idx)
      3'd4:    zero_blank = lz4;
      3'd5:    zero_blank = lz5;
      3'd6:    zero_blank = lz6;
      default: zero_blank = 1'b0;
    endcase
  end

  // Blink qualifiers are live so a record flag shows up mid-frame.
  always_comb begin
    blink_blank = 1'b0;
    if (!blink_on && WON) begin
      if (grp_of(slot_idx) == GRP_TIME) blink_blank = REC_BREAK_TIME;
      else                              blink_blank = REC_BREAK_MOVE;
    end
  end

  always_comb begin
    seg_d = {~dp_lit, seg_pat};
    dig_d = DIG_OFF;
    if ((prescaler >= P_DEAD) && !zero_blank && !blink_blank) begin
      dig_d = ~(8'd1 << slot_idx);
    end
  end

  always_ff @(posedge clock) begin
    if (RESET) begin
      prescaler   <= '0;
      slot_idx    <= 3'd0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      snap_digits <= '0;
      snap_best   <= 1'b0;
      seg_q       <= SEG_BLANK;
      dig_q       <= DIG_OFF;
    end else begin
      prescaler <= scan_wrap ? '0 : prescaler + 1'b1;
      if (scan_wrap) begin
        slot_idx <= slot_idx + 3'd1;
      end
      if (frame_wrap) begin
        snap_digits <= src_digits;
        snap_best   <= SHOW_BEST;
      end
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap) begin
        blink_on <= ~blink_on;
      end
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign SEG = seg_q;
  assign DIG = dig_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner at CLK_HZ=1000, SCAN_DIV=10, DEAD=2, BLINK_DIV=100:
// expected enabled slots are queued when inputs change and matched against captured frames.
module tb_seven_seg_scanner;

  logic       clock = 1'b0;
  logic       RESET;
  logic [7:0] cur_t  [4];
  logic [7:0] cur_m  [4];
  logic [7:0] best_t [4];
  logic [7:0] best_m [4];
  logic       SHOW_BEST, WON, REC_BREAK_TIME, REC_BREAK_MOVE;
  logic [7:0] SEG, DIG;

  always #5 clock = ~clock;

  seven_seg_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYCLES(2), .BLINK_HZ(5)
  ) dut (
    .clock(clock), .RESET(RESET),
    .TIME_NUM0(cur_t[0]), .TIME_NUM1(cur_t[1]), .TIME_NUM2(cur_t[2]), .TIME_NUM3(cur_t[3]),
    .MOVES_NUM0(cur_m[0]), .MOVES_NUM1(cur_m[1]), .MOVES_NUM2(cur_m[2]), .MOVES_NUM3(cur_m[3]),
    .BEST_TIME_NUM0(best_t[0]), .BEST_TIME_NUM1(best_t[1]),
    .BEST_TIME_NUM2(best_t[2]), .BEST_TIME_NUM3(best_t[3]),
    .BEST_MOVE_NUM0(best_m[0]), .BEST_MOVE_NUM1(best_m[1]),
    .BEST_MOVE_NUM2(best_m[2]), .BEST_MOVE_NUM3(best_m[3]),
    .SHOW_BEST(SHOW_BEST), .WON(WON),
    .REC_BREAK_TIME(REC_BREAK_TIME), .REC_BREAK_MOVE(REC_BREAK_MOVE),
    .SEG(SEG), .DIG(DIG)
  );

  typedef struct packed {
    logic [7:0] dig;
    logic [7:0] seg;
    logic [7:0] start;
    logic [7:0] len;
  } slot_t;

  slot_t      exp_q [$];
  slot_t      obs_q [$];
  logic [7:0] dig_q [$];
  int         nvec = 0;
  int         nerr = 0;
  int         cyc  = 0;

  function automatic logic [6:0] seg_pat(input logic [7:0] v);
    case (v)
      8'd0: return 7'b1000000;
      8'd1: return 7'b1111001;
      8'd2: return 7'b0100100;
      8'd3: return 7'b0110000;
      8'd4: return 7'b0011001;
      8'd5: return 7'b0010010;
      8'd6: return 7'b0000010;
      8'd7: return 7'b1111000;
      8'd8: return 7'b0000000;
      8'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Queue the enabled slots of one frame built from the present inputs
  // (or from an all-zero snapshot right after reset).
  task automatic push_frame(input bit best, input bit zero_snap);
    logic [7:0] d [8];
    slot_t e;
    bit blank;
    for (int i = 0; i < 4; i++) begin
      d[i]     = zero_snap ? 8'd0 : (best ? best_t[i] : cur_t[i]);
      d[i + 4] = zero_snap ? 8'd0 : (best ? best_m[i] : cur_m[i]);
    end
    for (int i = 0; i < 8; i++) begin
      blank = 1'b0;
      if (i >= 4 && i <= 6) begin
        blank = 1'b1;
        for (int j = 4; j <= i; j++) if (d[j] != 8'd0) blank = 1'b0;
      end
      if (!blank) begin
        e.dig   = ~(8'd1 << i);
        e.seg   = {~((i == 1) || (i == 7 && best)), seg_pat(d[i])};
        e.start = 8'(10 * i + 3);
        e.len   = 8'd8;
        exp_q.push_back(e);
      end
    end
  endtask

  // Record each run of a constant enabled DIG as one observed slot.
  task automatic capture(input int nframes);
    slot_t cur;
    bit    open;
    open = 1'b0;
    for (int i = 0; i < 80 * nframes; i++) begin
      @(posedge clock);
      cyc++;
      #1;
      if (open && DIG === cur.dig) begin
        cur.len = cur.len + 8'd1;
      end else begin
        if (open) obs_q.push_back(cur);
        open = 1'b0;
        if (DIG !== 8'hFF) begin
          cur.dig   = DIG;
          cur.seg   = SEG;
          cur.start = 8'((i % 80) + 1);
          cur.len   = 8'd1;
          open      = 1'b1;
        end
      end
    end
    if (open) obs_q.push_back(cur);
  endtask

  task automatic skip_frame();
    repeat (80) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic set_cur(input logic [7:0] t [4], input logic [7:0] m [4]);
    for (int i = 0; i < 4; i++) begin
      cur_t[i] = t[i];
      cur_m[i] = m[i];
    end
  endtask

  task automatic test_reset();
    slot_t e, o;
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur_t[i] = 8'd0; cur_m[i] = 8'd0; best_t[i] = 8'd0; best_m[i] = 8'd0;
    end
    SHOW_BEST = 1'b0; WON = 1'b0; REC_BREAK_TIME = 1'b0; REC_BREAK_MOVE = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      nvec++;
      if (SEG !== 8'hFF || DIG !== 8'hFF) begin
        nerr++;
        $display("FAIL reset_hold: got SEG=%h DIG=%h, exp SEG=ff DIG=ff", SEG, DIG);
      end
    end
    RESET = 1'b0;
    cyc   = 0;
    push_frame(1'b0, 1'b1);
    capture(1);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      nvec++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); nerr++;
        $display("FAIL reset_frame missing: exp dig=%h seg=%h start=%0d", e.dig, e.seg, e.start);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); nerr++;
        $display("FAIL reset_frame extra: got dig=%h seg=%h start=%0d", o.dig, o.seg, o.start);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          nerr++;
          $display("FAIL reset_frame: got dig=%h seg=%h start=%0d len=%0d, exp dig=%h seg=%h start=%0d len=%0d",
                   o.dig, o.seg, o.start, o.len, e.dig, e.seg, e.start, e.len);
        end
      end
    end
  endtask

  task automatic test_frames();
    logic [7:0] tbl [5][8];
    logic [7:0] t [4];
    logic [7:0] m [4];
    slot_t e, o;
    tbl = '{'{8'd1,  8'd2, 8'd3,  8'd4, 8'd0,  8'd0, 8'd4, 8'd2},
            '{8'd0,  8'd0, 8'd0,  8'd0, 8'd0,  8'd0, 8'd0, 8'd0},
            '{8'd5,  8'd9, 8'd12, 8'd7, 8'd0,  8'd5, 8'd0, 8'd0},
            '{8'd26, 8'd6, 8'd7,  8'd8, 8'd16, 8'd0, 8'd0, 8'd1},
            '{8'd9,  8'd8, 8'd0,  8'd6, 8'd0,  8'd0, 8'd0, 8'd9}};
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4; i++) begin
        t[i] = tbl[s][i];
        m[i] = tbl[s][i + 4];
      end
      set_cur(t, m);
      push_frame(1'b0, 1'b0);
      skip_frame();
      capture(1);
      while (exp_q.size() != 0 || obs_q.size() != 0) begin
        nvec++;
        if (obs_q.size() == 0) begin
          e = exp_q.pop_front(); nerr++;
          $display("FAIL frame%0d missing: exp dig=%h seg=%h start=%0d", s, e.dig, e.seg, e.start);
        end else if (exp_q.size() == 0) begin
          o = obs_q.pop_front(); nerr++;
          $display("FAIL frame%0d extra: got dig=%h seg=%h start=%0d", s, o.dig, o.seg, o.start);
        end else begin
          e = exp_q.pop_front(); o = obs_q.pop_front();
          if (o !== e) begin
            nerr++;
            $display("FAIL frame%0d: got dig=%h seg=%h start=%0d len=%0d, exp dig=%h seg=%h start=%0d len=%0d",
                     s, o.dig, o.seg, o.start, o.len, e.dig, e.seg, e.start, e.len);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] t [4];
    logic [7:0] m [4];
    slot_t e, o;
    t = '{8'd2, 8'd0, 8'd5, 8'd9};
    m = '{8'd0, 8'd0, 8'd0, 8'd6};
    set_cur(t, m);
    best_t = '{8'd3, 8'd1, 8'd4, 8'd8};
    best_m = '{8'd0, 8'd2, 8'd7, 8'd1};
    SHOW_BEST = 1'b0;
    skip_frame();
    push_frame(1'b0, 1'b0);
    fork
      capture(2);
      begin
        repeat (35) @(posedge clock);
        #2;
        SHOW_BEST = 1'b1;
        push_frame(1'b1, 1'b0);
      end
    join
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      nvec++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); nerr++;
        $display("FAIL snapshot missing: exp dig=%h seg=%h start=%0d", e.dig, e.seg, e.start);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); nerr++;
        $display("FAIL snapshot extra: got dig=%h seg=%h start=%0d", o.dig, o.seg, o.start);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          nerr++;
          $display("FAIL snapshot: got dig=%h seg=%h start=%0d len=%0d, exp dig=%h seg=%h start=%0d len=%0d",
                   o.dig, o.seg, o.start, o.len, e.dig, e.seg, e.start, e.len);
        end
      end
    end
    SHOW_BEST = 1'b0;
  endtask

  // Per-cycle DIG check while the record blink runs, first on the moves
  // group and then on the time group.
  task automatic test_blink();
    logic [7:0] t [4];
    logic [7:0] m [4];
    logic [7:0] e;
    int k, p, idx;
    bit off, grp_blank;
    t = '{8'd1, 8'd2, 8'd3, 8'd4};
    m = '{8'd1, 8'd2, 8'd3, 8'd4};
    set_cur(t, m);
    skip_frame();
    for (int phase = 0; phase < 2; phase++) begin
      WON            = 1'b1;
      REC_BREAK_MOVE = (phase == 0);
      REC_BREAK_TIME = (phase == 1);
      for (int n = 0; n < (phase == 0 ? 400 : 200); n++) begin
        k   = cyc + 1;
        p   = (k - 1) % 10;
        idx = ((k - 1) / 10) % 8;
        off = (((k - 1) / 100) % 2) == 1;
        grp_blank = off && ((idx >= 4) ? REC_BREAK_MOVE : REC_BREAK_TIME);
        dig_q.push_back((p >= 2 && !grp_blank) ? ~(8'd1 << idx) : 8'hFF);
        @(posedge clock);
        cyc++;
        #1;
        nvec++;
        e = dig_q.pop_front();
        if (DIG !== e) begin
          nerr++;
          $display("FAIL blink%0d cyc=%0d: got DIG=%h, exp DIG=%h", phase, cyc, DIG, e);
        end
      end
    end
    WON = 1'b0; REC_BREAK_MOVE = 1'b0; REC_BREAK_TIME = 1'b0;
    while (cyc % 80 != 0) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] t [4];
    logic [7:0] m [4];
    slot_t e, o;
    t = '{8'd1, 8'd2, 8'd3, 8'd4};
    m = '{8'd5, 8'd6, 8'd7, 8'd8};
    set_cur(t, m);
    skip_frame();
    repeat (35) @(posedge clock);
    #1;
    RESET = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
      nvec++;
      if (SEG !== 8'hFF || DIG !== 8'hFF) begin
        nerr++;
        $display("FAIL midframe_reset: got SEG=%h DIG=%h, exp SEG=ff DIG=ff", SEG, DIG);
      end
    end
    RESET = 1'b0;
    cyc   = 0;
    push_frame(1'b0, 1'b1);
    push_frame(1'b0, 1'b0);
    capture(2);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      nvec++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); nerr++;
        $display("FAIL restart missing: exp dig=%h seg=%h start=%0d", e.dig, e.seg, e.start);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); nerr++;
        $display("FAIL restart extra: got dig=%h seg=%h start=%0d", o.dig, o.seg, o.start);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          nerr++;
          $display("FAIL restart: got dig=%h seg=%h start=%0d len=%0d, exp dig=%h seg=%h start=%0d len=%0d",
                   o.dig, o.seg, o.start, o.len, e.dig, e.seg, e.start, e.len);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_snapshot();
    test_blink();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
